// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a 1-cycle-latency synchronous FIFO into a valid/ready
// stream through a small skid buffer. The pop decision depends only on local
// occupancy, never on the sink's ready, so backpressure has no combinational path
// back into the FIFO.
module fifo_stream_reader #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_fifo_empty,
    output logic                       o_fifo_pop,
    input  logic [N-1:0]               i_fifo_pop_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [N-1:0]               o_out_data,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    // Storage and bookkeeping
    logic [N-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_inflight;
    logic          r_drop;

    logic [LW:0]   w_occupancy;
    logic          w_room;
    logic          w_write;
    logic          w_xfer;
    logic [LW-1:0] w_level_next;

    // Pointers wrap with an explicit compare so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Occupancy counts the word already requested from the FIFO so a pop never
    // commits a slot that might not exist when the data lands.
    assign w_occupancy = {1'b0, r_level} + {{LW{1'b0}}, r_inflight};
    assign w_room      = (w_occupancy < (LW + 1)'(DEPTH));

    // Pop strobe is forced low during reset and flush.
    assign o_fifo_pop = i_rst_n & ~i_flush & ~i_fifo_empty & w_room;

    // A returning word is discarded if a flush is sampled on its arrival edge or
    // if it belongs to a request made before an earlier flush.
    assign w_write = r_inflight & ~r_drop & ~i_flush;

    // The sink's ready is ignored while flushing.
    assign w_xfer = o_out_valid & i_out_ready & ~i_flush;

    assign o_out_valid = (r_level != '0);
    assign o_out_data  = r_mem[r_rd_ptr];
    assign o_level     = r_level;

    // Next buffered-word count from arrival and departure of this cycle
    always_comb begin
        w_level_next = r_level;
        unique case ({w_write, w_xfer})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // Pointer, level, in-flight and drop-flag state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_inflight <= 1'b0;
            r_drop     <= r_inflight;
        end else begin
            r_inflight <= o_fifo_pop;
            r_drop     <= 1'b0;
            r_level    <= w_level_next;
            if (w_write) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_xfer) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    // Skid storage; cleared on reset so the idle output reads as zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[r_wr_ptr] <= i_fifo_pop_data;
        end
    end

    // Protocol and capacity invariants
    a_no_pop_when_empty : assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(o_fifo_pop && i_fifo_empty));

    a_level_bound : assert property (
        @(posedge i_clk) disable iff (!i_rst_n) r_level <= LW'(DEPTH));

    a_no_overflow : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (w_write && !w_xfer) |-> (r_level < LW'(DEPTH)));

    a_head_valid_on_xfer : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (i_out_ready && !i_flush && !o_out_valid) |-> !w_xfer);

endmodule
